// File: rtl/nes_pkg.sv
// Shared types and constants for the NES controller poll scheduler.
package nes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LATCH  = 3'd1,
        ST_CLK_HI = 3'd2,
        ST_CLK_LO = 3'd3,
        ST_DONE   = 3'd4
    } nes_state_e;

    // Button bit positions inside btn_l / btn_r (MSB-first shift order).
    localparam int BTN_A      = 7;
    localparam int BTN_B      = 6;
    localparam int BTN_SELECT = 5;
    localparam int BTN_START  = 4;
    localparam int BTN_UP     = 3;
    localparam int BTN_DOWN   = 2;
    localparam int BTN_LEFT   = 1;
    localparam int BTN_RIGHT  = 0;

    localparam int NES_HALF_PERIOD_DEF = 152;
    localparam int NES_POLL_PERIOD_DEF = 419583;

    // The pad drives active-low data; shift in the pressed (=1) sense.
    function automatic logic [6:0] shift_sample(input logic [6:0] cur, input logic data_n);
        return {cur[5:0], ~data_n};
    endfunction

endpackage

// File: rtl/poll_timer.sv
// Free-running 0..PERIOD-1 counter with a one-cycle tick at terminal count.
module poll_timer #(
    parameter int PERIOD = 100
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] TC = CW'(PERIOD - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: wrap at terminal count.
    always_comb begin
        if (cnt_q == TC) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == TC);

endmodule

// File: rtl/nes_poll_scheduler.sv
// Polls two NES pads at a fixed rate and publishes their button state.
// Optional newly-pressed masks are built when NES_PRESS_EDGE_EN is defined.
module nes_poll_scheduler
    import nes_pkg::*;
#(
    parameter int HALF_PERIOD = NES_HALF_PERIOD_DEF,
    parameter int POLL_PERIOD = NES_POLL_PERIOD_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       poll_en,
    input  logic       nes_data_l,
    input  logic       nes_data_r,
    output logic       nes_latch,
    output logic       nes_clk,
    output logic [7:0] btn_l,
    output logic [7:0] btn_r,
    output logic       btn_valid,
    output logic [7:0] press_l,
    output logic [7:0] press_r
);

    localparam int HB_W = $clog2(2 * HALF_PERIOD);
    localparam logic [HB_W-1:0] HB_LATCH_LAST = HB_W'(2 * HALF_PERIOD - 1);
    localparam logic [HB_W-1:0] HB_HALF_LAST  = HB_W'(HALF_PERIOD - 1);

    // The whole poll must fit between two ticks or polls would be dropped.
    if (POLL_PERIOD <= 16 * HALF_PERIOD + 2) begin : g_bad_cfg
        $error("nes_poll_scheduler: POLL_PERIOD must exceed 16*HALF_PERIOD+2");
    end

    logic tick_s;

    poll_timer #(
        .PERIOD (POLL_PERIOD)
    ) u_poll_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick_s)
    );

    nes_state_e      state_q, state_d;
    logic [HB_W-1:0] hb_q, hb_d;
    logic [2:0]      bit_q, bit_d;
    logic [6:0]      shl_q, shl_d;
    logic [6:0]      shr_q, shr_d;
    logic            latch_q, latch_d;
    logic            nclk_q, nclk_d;
    logic [7:0]      btn_l_q, btn_l_d;
    logic [7:0]      btn_r_q, btn_r_d;
    logic            valid_q, valid_d;
    logic [7:0]      new_l_s, new_r_s;

    // Eighth sample completes the byte directly from the shift registers.
    assign new_l_s = {shl_q, ~nes_data_l};
    assign new_r_s = {shr_q, ~nes_data_r};

`ifdef NES_PRESS_EDGE_EN
    logic [7:0] press_l_q, press_l_d;
    logic [7:0] press_r_q, press_r_d;
`endif

    // Poll sequencer: next state and next registered outputs.
    always_comb begin
        state_d = state_q;
        hb_d    = hb_q;
        bit_d   = bit_q;
        shl_d   = shl_q;
        shr_d   = shr_q;
        latch_d = latch_q;
        nclk_d  = nclk_q;
        btn_l_d = btn_l_q;
        btn_r_d = btn_r_q;
        valid_d = 1'b0;
`ifdef NES_PRESS_EDGE_EN
        press_l_d = 8'h00;
        press_r_d = 8'h00;
`endif
        case (state_q)
            ST_IDLE: begin
                if (tick_s && poll_en) begin
                    state_d = ST_LATCH;
                    latch_d = 1'b1;
                    hb_d    = '0;
                    bit_d   = 3'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LATCH: begin
                if (hb_q == HB_LATCH_LAST) begin
                    state_d = ST_CLK_HI;
                    latch_d = 1'b0;
                    nclk_d  = 1'b1;
                    hb_d    = '0;
                    shl_d   = shift_sample(shl_q, nes_data_l);
                    shr_d   = shift_sample(shr_q, nes_data_r);
                end else begin
                    hb_d = hb_q + HB_W'(1);
                end
            end
            ST_CLK_HI: begin
                if (hb_q == HB_HALF_LAST) begin
                    state_d = ST_CLK_LO;
                    nclk_d  = 1'b0;
                    hb_d    = '0;
                end else begin
                    hb_d = hb_q + HB_W'(1);
                end
            end
            ST_CLK_LO: begin
                if (hb_q == HB_HALF_LAST) begin
                    hb_d = '0;
                    if (bit_q == 3'd6) begin
                        state_d = ST_DONE;
                        btn_l_d = new_l_s;
                        btn_r_d = new_r_s;
                        valid_d = 1'b1;
`ifdef NES_PRESS_EDGE_EN
                        press_l_d = new_l_s & ~btn_l_q;
                        press_r_d = new_r_s & ~btn_r_q;
`endif
                    end else begin
                        state_d = ST_CLK_HI;
                        nclk_d  = 1'b1;
                        bit_d   = bit_q + 3'd1;
                        shl_d   = shift_sample(shl_q, nes_data_l);
                        shr_d   = shift_sample(shr_q, nes_data_r);
                    end
                end else begin
                    hb_d = hb_q + HB_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                latch_d = 1'b0;
                nclk_d  = 1'b0;
                hb_d    = '0;
            end
        endcase
    end

    // Sequencer state and output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            hb_q    <= '0;
            bit_q   <= 3'd0;
            shl_q   <= 7'h00;
            shr_q   <= 7'h00;
            latch_q <= 1'b0;
            nclk_q  <= 1'b0;
            btn_l_q <= 8'h00;
            btn_r_q <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hb_q    <= hb_d;
            bit_q   <= bit_d;
            shl_q   <= shl_d;
            shr_q   <= shr_d;
            latch_q <= latch_d;
            nclk_q  <= nclk_d;
            btn_l_q <= btn_l_d;
            btn_r_q <= btn_r_d;
            valid_q <= valid_d;
        end
    end

`ifdef NES_PRESS_EDGE_EN
    // Newly-pressed mask registers, live only alongside btn_valid.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            press_l_q <= 8'h00;
            press_r_q <= 8'h00;
        end else begin
            press_l_q <= press_l_d;
            press_r_q <= press_r_d;
        end
    end

    assign press_l = press_l_q;
    assign press_r = press_r_q;
`else
    assign press_l = 8'h00;
    assign press_r = 8'h00;
`endif

    assign nes_latch = latch_q;
    assign nes_clk   = nclk_q;
    assign btn_l     = btn_l_q;
    assign btn_r     = btn_r_q;
    assign btn_valid = valid_q;

endmodule

// File: doc/nes_poll_scheduler.md
NES_POLL_SCHEDULER -- requirements
Module: nes_poll_scheduler

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 152, meaning clk cycles per NES half-bit (~6 us).
REQ-002 SHALL have parameter POLL_PERIOD, default 419583, meaning clk cycles between poll ticks (~60 Hz).
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port poll_en  input  1  enables starting new polls.
REQ-006 SHALL have ports nes_data_l, nes_data_r  input  1 each  serial data from the left/right controller, active-low.
REQ-007 SHALL have ports nes_latch, nes_clk  output  1 each  latch and clock, shared by both controllers.
REQ-008 SHALL have ports btn_l, btn_r  output  8 each  button state, 1 = pressed; [7]A [6]B [5]Select [4]Start [3]Up [2]Down [1]Left [0]Right.
REQ-009 SHALL have port btn_valid  output  1  one-cycle strobe when btn_l/btn_r update.
REQ-010 SHALL have ports press_l, press_r  output  8 each  newly-pressed masks.

Function
REQ-011 SHALL run a free-running poll timer 0..POLL_PERIOD-1 that asserts tick for one cycle at terminal count, then wraps to 0.
REQ-012 SHALL implement FSM states IDLE, LATCH, CLK_HI, CLK_LO, DONE.
REQ-013 IDLE SHALL go to LATCH on the cycle after tick when poll_en=1; a tick outside IDLE or with poll_en=0 SHALL be dropped.
REQ-014 SHALL hold nes_latch high for exactly 2*HALF_PERIOD cycles in LATCH and sample both data inputs (bit A) on its last cycle.
REQ-015 For bits 1..7 SHALL hold nes_clk high HALF_PERIOD cycles (CLK_HI), then low HALF_PERIOD cycles (CLK_LO), sampling on the last CLK_LO cycle.
REQ-016 SHALL produce exactly 7 nes_clk pulses per poll; nes_latch and nes_clk SHALL never be high together.
REQ-017 SHALL store samples inverted (pressed = 1) in MSB-first order: the first sample goes to [7], the eighth to [0].
REQ-018 After the eighth sample SHALL enter DONE for one cycle: btn_l/btn_r load, btn_valid=1, then return to IDLE.
REQ-019 btn_valid SHALL assert exactly 16*HALF_PERIOD cycles after nes_latch rises.
REQ-020 btn_l/btn_r SHALL hold their value between DONE cycles.
REQ-021 poll_en falling mid-poll SHALL NOT abort the poll; the poll completes normally.
REQ-022 The half-bit counter SHALL be ceil(log2(2*HALF_PERIOD)) bits wide and the poll counter ceil(log2(POLL_PERIOD)) bits wide, with no overflow.
REQ-023 SHALL require POLL_PERIOD > 16*HALF_PERIOD+2 (elaboration check).

Reset
REQ-024 On reset_n=0 at a clk edge: state=IDLE, both counters=0, nes_latch=0, nes_clk=0, btn_l=btn_r=0, btn_valid=0, press_l=press_r=0.
REQ-025 Reset mid-poll SHALL abort the poll and discard partial samples; outputs SHALL NOT update.

Configuration
REQ-026 With NES_PRESS_EDGE_EN defined, press_x SHALL equal new_btn & ~old_btn during the DONE cycle only and be 0 otherwise, where old_btn is the previous btn_x (0 after reset).
REQ-027 Without NES_PRESS_EDGE_EN, press_l/press_r SHALL be constant 0 and no edge registers SHALL be built.

Structure
REQ-028 Shared package nes_pkg SHALL hold the FSM state enum, button bit-index constants (BTN_A..BTN_RIGHT) and default HALF_PERIOD/POLL_PERIOD constants.
REQ-029 SHALL instantiate one sub-module, poll_timer (parameterised terminal-count counter with tick output); everything else SHALL be inline.

Verification (HALF_PERIOD=4, POLL_PERIOD=100)
REQ-030 Reset held 3 cycles -> all outputs 0; nes_latch and nes_clk low.
REQ-031 poll_en=1, left data drives 0 for A and Up, 1 otherwise; right all 1 -> nes_latch high 8 cycles, 7 nes_clk pulses of 4 high/4 low, btn_valid 64 cycles after latch rise, btn_l=8'h88, btn_r=8'h00.
REQ-032 poll_en=0 across two ticks -> nes_latch never rises; btn_valid never asserts.
REQ-033 reset_n pulsed low during the third nes_clk pulse -> immediate IDLE, outputs 0; the next tick starts a clean poll.
REQ-034 With NES_PRESS_EDGE_EN, A held for two polls -> press_l=8'h80 on the first DONE and 8'h00 on the second; btn_l=8'h80 both times.
REQ-035 poll_en dropped 10 cycles after latch rise -> poll completes with btn_valid at cycle 64; no latch on the next tick.
